// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response and decoder
// handshake bundle around the fetch unit.
interface fetch_unit_if;
  logic        imemReq;
  logic        imemGnt;
  logic [31:0] imemAddr;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic        instrIllegal;
  logic        redirect;
  logic [31:0] redirectPC;

  modport master (
    output imemReq, imemAddr,
    output instrValid, instr, instrPC, instrIllegal,
    input  imemGnt, imemRvalid, imemRdata,
    input  instrReady, redirect, redirectPC
  );

  modport slave (
    input  imemReq, imemAddr,
    input  instrValid, instr, instrPC, instrIllegal,
    output imemGnt, imemRvalid, imemRdata,
    output instrReady, redirect, redirectPC
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a DEPTH-entry buffer.
// Define FETCH_ILLEGAL_CHECK_EN to flag non-32-bit encodings.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          resetn,
  fetch_unit_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NE = 1 << AW;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          req_en_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [31:0]   data_q [NE];
  logic [31:0]   pc_q   [NE];

  logic xfer, rsp, drop_rsp, push, pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.imemReq = req_en_q
    && (state_q == ST_FETCH)
    && (({1'b0, outst_q} + {1'b0, occ_q})
        < (CW + 1)'(DEPTH));
  assign bus.imemAddr = fetch_pc_q;

  assign xfer     = bus.imemReq & bus.imemGnt;
  assign rsp      = bus.imemRvalid
                  & (outst_q != '0);
  assign drop_rsp = rsp & (drop_q != '0);
  assign push     = rsp & ~drop_rsp
                  & ~bus.redirect;
  assign pop      = bus.instrValid
                  & bus.instrReady
                  & ~bus.redirect;

  assign bus.instrValid = (occ_q != '0);
  assign bus.instr      = data_q[head_q];
  assign bus.instrPC    = pc_q[head_q];

  // Next-state: counters, pointers and redirect override.
  always_comb begin
    outst_d    = outst_q + CW'(xfer) - CW'(rsp);
    drop_d     = drop_q - CW'(drop_rsp);
    state_d    = (drop_d == '0) ? ST_FETCH : state_q;
    fetch_pc_d = fetch_pc_q
               + (xfer ? 32'd4 : 32'd0);
    rsp_pc_d   = rsp_pc_q
               + (push ? 32'd4 : 32'd0);
    occ_d      = occ_q + CW'(push) - CW'(pop);
    head_d     = pop ? nxt(head_q) : head_q;
    tail_d     = push ? nxt(tail_q) : tail_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirectPC
                 & 32'hFFFF_FFFC;
      rsp_pc_d   = fetch_pc_d;
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = outst_d;
      state_d    = (outst_d != '0)
                 ? ST_FLUSH : ST_FETCH;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_FETCH;
      req_en_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      occ_q      <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_en_q   <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      occ_q      <= occ_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Buffer storage written at the tail on push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NE; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[tail_q] <= bus.imemRdata;
      pc_q[tail_q]   <= rsp_pc_q;
    end
  end

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic ill_q [NE];

  // Illegal flag computed once, when the word enters the buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NE; i++)
        ill_q[i] <= 1'b0;
    end else if (push) begin
      ill_q[tail_q] <= ~&bus.imemRdata[1:0];
    end
  end

  assign bus.instrIllegal = ill_q[head_q];
`else
  assign bus.instrIllegal = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/decoder environment with an
// instruction-stream reference model for fetch_unit.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic resetn;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (RPC),
    .DEPTH    (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend[$];
  int cyc;
  int n_cmp;
  int n_bad;

  int gnt_pct, rsp_pct, rdy_pct, lat_max;
  bit hold;
  bit redir_en;
  logic [31:0] redir_pc;

  logic        o_req, o_valid, o_ill;
  logic [31:0] o_addr, o_pc, o_ins;
  bit granted, popped;

  function automatic logic [31:0] memf(
    input logic [31:0] a
  );
    if (a == 32'h300) return 32'h0000_4501;
    if (a == 32'h304) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic exp_ill(
    input logic [31:0] w
  );
`ifdef FETCH_ILLEGAL_CHECK_EN
    return w[1:0] != 2'b11;
`else
    return 1'b0 & w[0];
`endif
  endfunction

  // One clock of environment: observe, then drive.
  task automatic step();
    int d;
    @(negedge clk);
    cyc++;
    o_req   = bus.imemReq;
    o_addr  = bus.imemAddr;
    o_valid = bus.instrValid;
    o_pc    = bus.instrPC;
    o_ins   = bus.instr;
    o_ill   = bus.instrIllegal;
    bus.imemGnt = ($urandom_range(99) < gnt_pct);
    bus.imemRvalid = 1'b0;
    bus.imemRdata  = '0;
    if (!hold && pend.size() > 0
        && pend[0].due <= cyc
        && $urandom_range(99) < rsp_pct) begin
      bus.imemRvalid = 1'b1;
      bus.imemRdata  = memf(pend[0].addr);
      void'(pend.pop_front());
    end
    bus.instrReady = ($urandom_range(99) < rdy_pct);
    bus.redirect   = redir_en;
    bus.redirectPC = redir_pc;
    granted = o_req && bus.imemGnt;
    if (granted) begin
      d = cyc + int'($urandom_range(lat_max, 1));
      if (pend.size() > 0
          && d < pend[pend.size()-1].due)
        d = pend[pend.size()-1].due;
      pend.push_back('{o_addr, d});
    end
    popped = o_valid && bus.instrReady;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.imemGnt = 0; bus.imemRvalid = 0;
    bus.imemRdata = '0; bus.instrReady = 0;
    bus.redirect = 0; bus.redirectPC = '0;
    pend.delete();
    redir_en = 0; hold = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    gnt_pct = 100; rsp_pct = 100;
    rdy_pct = 0; lat_max = 1;
    repeat (6) step();
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (bus.imemReq !== 1'b0 || bus.instrValid !== 1'b0
        || bus.instr !== 32'h0 || bus.instrPC !== 32'h0
        || bus.instrIllegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs got req=%b v=%b i=%h pc=%h il=%b want 0",
        bus.imemReq, bus.instrValid, bus.instr,
        bus.instrPC, bus.instrIllegal);
    end
    pend.delete();
    @(negedge clk);
    resetn = 1'b1;
    bus.imemGnt = 1'b0;
    bus.imemRvalid = 1'b1;
    bus.imemRdata  = 32'hDEAD_BEEF;
    gnt_pct = 0;
    step();
    n_cmp++;
    if (o_req !== 1'b1 || o_addr !== RPC) begin
      n_bad++;
      $display("FAIL first_req got req=%b addr=%h want 1 %h",
        o_req, o_addr, RPC);
    end
    step();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stale_rsp got valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    int np;
    do_reset();
    gnt_pct = 100; rsp_pct = 100;
    rdy_pct = 100; lat_max = 1;
    ea = RPC; ep = RPC; np = 0;
    repeat (40) begin
      step();
      if (granted) begin
        n_cmp++;
        if (o_addr !== ea) begin
          n_bad++;
          $display("FAIL stream_addr got %h want %h", o_addr, ea);
        end
        ea += 4;
      end
      if (popped) begin
        n_cmp++;
        if (o_pc !== ep || o_ins !== memf(ep)) begin
          n_bad++;
          $display("FAIL stream_pop got %h/%h want %h/%h",
            o_pc, o_ins, ep, memf(ep));
        end
        ep += 4; np++;
      end
    end
    n_cmp++;
    if (np < 15) begin
      n_bad++;
      $display("FAIL stream_rate got %0d pops want >=15", np);
    end
  endtask

  task automatic test_backpressure();
    int ng;
    bit seen;
    do_reset();
    gnt_pct = 100; rsp_pct = 100;
    rdy_pct = 0; lat_max = 1;
    ng = 0;
    repeat (10) begin
      step();
      if (granted) ng++;
      if (o_valid) begin
        n_cmp++;
        if (o_pc !== RPC || o_ins !== memf(RPC)) begin
          n_bad++;
          $display("FAIL bp_hold got %h/%h want %h/%h",
            o_pc, o_ins, RPC, memf(RPC));
        end
      end
    end
    n_cmp++;
    if (ng != 2 || o_req !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_grants got %0d req=%b want 2 0", ng, o_req);
    end
    rdy_pct = 100;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (granted) begin
        seen = 1;
        n_cmp++;
        if (o_addr !== RPC + 8) begin
          n_bad++;
          $display("FAIL bp_resume got %h want %h", o_addr, RPC + 8);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL bp_resume got no grant want %h", RPC + 8);
    end
  endtask

  task automatic test_flush();
    int ng;
    bit seen;
    logic [31:0] ea;
    do_reset();
    gnt_pct = 0; rsp_pct = 100;
    rdy_pct = 100; lat_max = 1;
    hold = 1;
    redir_en = 1; redir_pc = 32'h10;
    step();
    redir_en = 0;
    gnt_pct = 100;
    ng = 0; ea = 32'h10;
    for (int i = 0; i < 10 && ng < 2; i++) begin
      step();
      if (granted) begin
        n_cmp++;
        if (o_addr !== ea) begin
          n_bad++;
          $display("FAIL flush_req got %h want %h", o_addr, ea);
        end
        ea += 4; ng++;
      end
    end
    redir_en = 1; redir_pc = 32'h203;
    step();
    redir_en = 0;
    hold = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (o_valid) begin
        seen = 1;
        n_cmp++;
        if (o_pc !== 32'h200 || o_ins !== memf(32'h200)) begin
          n_bad++;
          $display("FAIL flush_first got %h/%h want %h/%h",
            o_pc, o_ins, 32'h200, memf(32'h200));
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL flush_first got none want pc 200");
    end
  endtask

  task automatic test_stall();
    do_reset();
    gnt_pct = 0; rsp_pct = 100;
    rdy_pct = 100; lat_max = 1;
    redir_en = 1; redir_pc = 32'h40;
    step();
    redir_en = 0;
    repeat (5) begin
      step();
      n_cmp++;
      if (o_req !== 1'b1 || o_addr !== 32'h40) begin
        n_bad++;
        $display("FAIL stall_hold got %b/%h want 1/40", o_req, o_addr);
      end
    end
    redir_en = 1; redir_pc = 32'h80;
    step();
    redir_en = 0;
    step();
    n_cmp++;
    if (o_addr !== 32'h80) begin
      n_bad++;
      $display("FAIL stall_redir got %h want 80", o_addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea, ep;
    int ng, np;
    do_reset();
    gnt_pct = 0; rsp_pct = 100;
    rdy_pct = 100; lat_max = 1;
    redir_en = 1; redir_pc = 32'hFFFF_FFFE;
    step();
    redir_en = 0;
    gnt_pct = 100;
    ea = 32'hFFFF_FFFC; ep = ea;
    ng = 0; np = 0;
    for (int i = 0; i < 20 && np < 2; i++) begin
      step();
      if (granted && ng < 2) begin
        n_cmp++;
        if (o_addr !== ea) begin
          n_bad++;
          $display("FAIL wrap_addr got %h want %h", o_addr, ea);
        end
        ea += 4; ng++;
      end
      if (popped) begin
        n_cmp++;
        if (o_pc !== ep || o_ins !== memf(ep)) begin
          n_bad++;
          $display("FAIL wrap_pop got %h/%h want %h/%h",
            o_pc, o_ins, ep, memf(ep));
        end
        ep += 4; np++;
      end
    end
    if (np < 2) begin
      n_cmp++; n_bad++;
      $display("FAIL wrap_pop got %0d pops want 2", np);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ep;
    int np;
    do_reset();
    gnt_pct = 0; rsp_pct = 100;
    rdy_pct = 100; lat_max = 1;
    redir_en = 1; redir_pc = 32'h300;
    step();
    redir_en = 0;
    gnt_pct = 100;
    ep = 32'h300; np = 0;
    for (int i = 0; i < 20 && np < 2; i++) begin
      step();
      if (popped) begin
        n_cmp++;
        if (o_pc !== ep || o_ins !== memf(ep)
            || o_ill !== exp_ill(memf(ep))) begin
          n_bad++;
          $display("FAIL illegal got %h/%h/%b want %h/%h/%b",
            o_pc, o_ins, o_ill, ep, memf(ep), exp_ill(memf(ep)));
        end
        ep += 4; np++;
      end
    end
    if (np < 2) begin
      n_cmp++; n_bad++;
      $display("FAIL illegal got %0d pops want 2", np);
    end
  endtask

  task automatic test_random();
    logic [31:0] ep, pa, ppc, pins;
    bit zchk, pstall, phold;
    int rb, np;
    do_reset();
    ep = RPC; zchk = 0; pstall = 0; phold = 0;
    rb = 0; np = 0; pa = '0; ppc = '0; pins = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = $urandom_range(100, 30);
        rsp_pct = $urandom_range(100, 30);
        rdy_pct = $urandom_range(100, 20);
        lat_max = $urandom_range(4, 1);
      end
      if (rb == 0 && $urandom_range(99) < 3)
        rb = $urandom_range(3, 1);
      redir_en = (rb > 0);
      redir_pc = ($urandom_range(9) == 0)
               ? 32'hFFFF_FFF0 | $urandom_range(15)
               : $urandom;
      if (rb > 0) rb--;
      step();
      n_cmp++;
      if (o_addr[1:0] !== 2'b00) begin
        n_bad++;
        $display("FAIL rnd_align got %h want xx..00", o_addr);
      end
      if (zchk) begin
        n_cmp++;
        if (o_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_clear got valid=%b want 0", o_valid);
        end
      end
      if (pstall) begin
        n_cmp++;
        if (o_req !== 1'b1 || o_addr !== pa) begin
          n_bad++;
          $display("FAIL rnd_reqhold got %b/%h want 1/%h",
            o_req, o_addr, pa);
        end
      end
      if (phold) begin
        n_cmp++;
        if (o_valid !== 1'b1 || o_pc !== ppc || o_ins !== pins) begin
          n_bad++;
          $display("FAIL rnd_headhold got %b/%h/%h want 1/%h/%h",
            o_valid, o_pc, o_ins, ppc, pins);
        end
      end
      if (popped) begin
        n_cmp++;
        if (o_pc !== ep || o_ins !== memf(ep)
            || o_ill !== exp_ill(memf(ep))) begin
          n_bad++;
          $display("FAIL rnd_pop got %h/%h/%b want %h/%h/%b",
            o_pc, o_ins, o_ill, ep, memf(ep), exp_ill(memf(ep)));
        end
        ep += 4; np++;
      end
      zchk   = redir_en;
      pstall = o_req && !bus.imemGnt && !redir_en;
      pa     = o_addr;
      phold  = o_valid && !bus.instrReady && !redir_en;
      ppc    = o_pc;
      pins   = o_ins;
      if (redir_en) ep = redir_pc & 32'hFFFF_FFFC;
    end
    redir_en = 0;
    n_cmp++;
    if (np < 200) begin
      n_bad++;
      $display("FAIL rnd_progress got %0d pops want >=200", np);
    end
  endtask

  initial begin
    resetn = 1'b0;
    cyc = 0; n_cmp = 0; n_bad = 0;
    gnt_pct = 0; rsp_pct = 0;
    rdy_pct = 0; lat_max = 1;
    hold = 0; redir_en = 0; redir_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall();
    test_wrap();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
